instr_sequencer: RTL and testbench

//   Instruction issuer for mipscpu: holds a small program RAM, then presents each
//   32-bit word on instrword and signals it with a one-cycle newinstr pulse.

---
 rtl/instr_sequencer.sv | 99 +++++++++
 tb/tb_instr_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Program RAM plus issue FSM: presents each stored word on instrword, strobes
// newinstr for one cycle, then waits SETTLE cycles before fetching the next.
module instr_sequencer #(
  parameter int          AW      = 4,
  parameter int          SETTLE  = 16,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [31:0]   instrword,
  output logic          newinstr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] PULSE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state;
  logic [AW:0]   len;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [0:(2**AW)-1];
  logic [31:0]   fword;
  logic [AW:0]   pc_next;

  assign fword    = mem[pc];
  assign pc_next  = {1'b0, pc} + (AW+1)'(1);
  assign busy     = (state == FETCH) || (state == PULSE) || (state == WAIT);
  // Decoded from state so reset drops the strobe asynchronously.
  assign newinstr = (state == PULSE);
  assign finished = (state == DONE);

  // RAM is deliberately not reset; contents survive reset.
  always_ff @(posedge clock) begin
    if (load_en && !busy)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      instrword <= '0;
      pc        <= '0;
      len       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (prog_len == '0) begin
              state <= DONE;
            end else begin
              state <= FETCH;
              pc    <= '0;
              len   <= prog_len;
            end
          end
        end
        FETCH: begin
          if (fword[31:26] == HALT_OP) begin
            state <= DONE;
          end else begin
            instrword <= fword;
            state     <= PULSE;
          end
        end
        PULSE: begin
          cnt   <= CW'(SETTLE - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (pc_next == len) begin
              state <= DONE;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: words, pc and spacing of every pulse are
// compared against hand-computed values.
module tb_instr_sequencer;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [31:0]   instrword;
  logic          newinstr;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  int np;

  logic [31:0] prog5 [0:4];

  instr_sequencer #(.AW(AW), .SETTLE(16), .HALT_OP(6'h3F)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len),
    .instrword(instrword), .newinstr(newinstr), .pc(pc), .busy(busy),
    .finished(finished)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic do_start(input logic [AW:0] n);
    start = 1'b1; prog_len = n;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_pulse(input string tag, input logic [31:0] w, input logic [AW-1:0] p,
                            input int gap, input bit stay);
    int n = 0;
    while (newinstr !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (newinstr !== 1'b1) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_word"}, instrword, w);
      check({tag, "_pc"}, 32'(pc), 32'(p));
      if (gap > 0) check({tag, "_gap"}, 32'(cyc - last_cyc), 32'(gap));
      last_cyc = cyc;
      if (!stay) begin
        @(negedge clock);
        check({tag, "_single"}, 32'(newinstr), 32'd0);
      end
    end
  endtask

  task automatic wait_done(output int pulses);
    int n = 0;
    pulses = 0;
    while (finished !== 1'b1 && n < 60) begin
      @(negedge clock);
      if (newinstr === 1'b1) pulses++;
      n++;
    end
    check("done_reached", 32'(finished), 32'd1);
  endtask

  task automatic load_prog5();
    for (int i = 0; i < 5; i++) load(AW'(i), prog5[i]);
  endtask

  initial begin
    prog5[0] = 32'h8C010000; prog5[1] = 32'h8C020001; prog5[2] = 32'h8C030002;
    prog5[3] = 32'h00222020; prog5[4] = 32'h00832822;

    // 1: reset state, RAM survives reset
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    load(0, 32'h12345678);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_instrword", instrword, 32'h0);
    check("rst_newinstr", 32'(newinstr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    do_start(1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_pulse("t1_p0", 32'h12345678, 0, 0, 1'b0);
    wait_done(np);
    check("t1_extra_pulses", 32'(np), 32'd0);

    // 2: five-word run, 18-cycle spacing
    load_prog5();
    do_start(5);
    for (int i = 0; i < 5; i++)
      wait_pulse($sformatf("t2_p%0d", i), prog5[i], AW'(i), (i == 0) ? 0 : 18, 1'b0);
    wait_done(np);
    check("t2_extra_pulses", 32'(np), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_pc", 32'(pc), 32'd4);
    check("t2_word", instrword, 32'h00832822);

    // 3: halt opcode ends run without issuing
    load(0, 32'h8C010000); load(1, 32'hFC000000); load(2, 32'h00222020);
    do_start(3);
    check("t3_finished_clr", 32'(finished), 32'd0);
    wait_pulse("t3_p0", 32'h8C010000, 0, 0, 1'b0);
    wait_done(np);
    check("t3_extra_pulses", 32'(np), 32'd0);
    check("t3_word", instrword, 32'h8C010000);
    check("t3_pc", 32'(pc), 32'd1);

    // full-depth run: pc stops at 15
    for (int i = 0; i < 16; i++) load(AW'(i), 32'h01000000 + 32'(i));
    do_start(16);
    for (int i = 0; i < 16; i++)
      wait_pulse($sformatf("tf_p%0d", i), 32'h01000000 + 32'(i), AW'(i), (i == 0) ? 0 : 18, 1'b0);
    wait_done(np);
    check("tf_pc", 32'(pc), 32'd15);
    check("tf_word", instrword, 32'h0100000F);

    // start and load in the same idle cycle: fetch sees the new word
    start = 1'b1; prog_len = 1; load_en = 1'b1; load_addr = 0; load_data = 32'hAABBCCDD;
    @(negedge clock);
    start = 1'b0; load_en = 1'b0;
    wait_pulse("tsl_p0", 32'hAABBCCDD, 0, 0, 1'b0);
    wait_done(np);

    // 5: start/load_en during WAIT ignored
    load_prog5();
    do_start(5);
    wait_pulse("t5_p0", prog5[0], 0, 0, 1'b0);
    start = 1'b1; prog_len = 2; load_en = 1'b1; load_addr = 1; load_data = 32'hFC000000;
    @(negedge clock);
    start = 1'b0; load_en = 1'b0;
    for (int i = 1; i < 5; i++)
      wait_pulse($sformatf("t5_p%0d", i), prog5[i], AW'(i), 18, 1'b0);
    wait_done(np);
    check("t5_pc", 32'(pc), 32'd4);

    // 6: reset during the 3rd pulse
    do_start(5);
    wait_pulse("t6_p0", prog5[0], 0, 0, 1'b0);
    wait_pulse("t6_p1", prog5[1], 1, 18, 1'b0);
    wait_pulse("t6_p2", prog5[2], 2, 18, 1'b1);
    reset = 1'b0;
    #1;
    check("t6_newinstr", 32'(newinstr), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_word", instrword, 32'h0);
    check("t6_pc", 32'(pc), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    do_start(5);
    for (int i = 0; i < 5; i++)
      wait_pulse($sformatf("t6r_p%0d", i), prog5[i], AW'(i), (i == 0) ? 0 : 18, 1'b0);
    wait_done(np);

    // 4: zero-length run from IDLE
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t4_pre_finished", 32'(finished), 32'd0);
    do_start(0);
    check("t4_finished", 32'(finished), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    np = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (busy === 1'b1 || newinstr === 1'b1) np++;
    end
    check("t4_no_activity", 32'(np), 32'd0);
    check("t4_pc", 32'(pc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
